// File: rtl/bubble_sort_ctrl.sv
// bubble_sort_ctrl: in-place ascending unsigned bubble sort of mem[BASE..BASE+N-1]; ports Clk, Rst_n, Start, ReadData in; Address, WriteData, MemWrite, MemRead, Busy, Done, SwapCount out; define BSORT_EARLY_EXIT_EN to end after a pass with no swaps
module bubble_sort_ctrl #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8,
  parameter int N      = 32,
  parameter int BASE   = 0
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              Start,
  input  logic [DATA_W-1:0] ReadData,
  output logic [ADDR_W-1:0] Address,
  output logic [DATA_W-1:0] WriteData,
  output logic              MemWrite,
  output logic              MemRead,
  output logic              Busy,
  output logic              Done,
  output logic [15:0]       SwapCount
);
  localparam logic [2:0] IDLE = 3'd0, RD_A = 3'd1, RD_B = 3'd2, CMP = 3'd3,
                         WR_A = 3'd4, WR_B = 3'd5, DONE = 3'd6;
  localparam logic [ADDR_W-1:0] LAST_P = ADDR_W'(N - 2);
  localparam logic [ADDR_W-1:0] BASE_A = ADDR_W'(BASE);
`ifdef BSORT_EARLY_EXIT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif
  logic [2:0]        state;
  logic [ADDR_W-1:0] p, i;
  logic [DATA_W-1:0] reg_a, reg_b;
  logic              swapped, gt, adv, last_i, early;
  assign gt     = reg_a > reg_b;
  assign adv    = (state == CMP && !gt) || state == WR_B;
  assign last_i = i == LAST_P - p;
  // a swap committed in this very WR_B cycle counts as a swap in the pass
  assign early  = EARLY && !swapped && state != WR_B;
  assign Address   = (state == RD_A || state == WR_A) ? BASE_A + i :
                     (state == RD_B || state == WR_B) ? BASE_A + i + 1'b1 : '0;
  assign WriteData = state == WR_A ? reg_b : state == WR_B ? reg_a : '0;
  assign MemWrite  = state == WR_A || state == WR_B;
  assign MemRead   = state == RD_A || state == RD_B;
  assign Busy      = state >= RD_A && state <= WR_B;
  assign Done      = state == DONE;
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state     <= IDLE;
      p         <= '0;
      i         <= '0;
      reg_a     <= '0;
      reg_b     <= '0;
      swapped   <= 1'b0;
      SwapCount <= '0;
    end else begin
      case (state)
        IDLE, DONE: if (Start) begin
          state     <= RD_A;
          p         <= '0;
          i         <= '0;
          swapped   <= 1'b0;
          SwapCount <= '0;
        end
        RD_A: begin
          reg_a <= ReadData;
          state <= RD_B;
        end
        RD_B: begin
          reg_b <= ReadData;
          state <= CMP;
        end
        CMP:  state <= gt ? WR_A : state;
        WR_A: state <= WR_B;
        WR_B: begin
          SwapCount <= SwapCount + {15'd0, SwapCount != 16'hFFFF};
          swapped   <= 1'b1;
        end
        default: state <= IDLE;
      endcase
      // advance overrides the per-state next state above
      if (adv) begin
        if (!last_i) begin
          i     <= i + 1'b1;
          state <= RD_A;
        end else if (p == LAST_P || early) begin
          state <= DONE;
        end else begin
          p       <= p + 1'b1;
          i       <= '0;
          swapped <= 1'b0;
          state   <= RD_A;
        end
      end
    end
  end
endmodule

// File: tb/tb_bubble_sort_ctrl.sv
// tb_bubble_sort_ctrl: checks bubble_sort_ctrl against an inversion-count model of bubble sort
module tb_bubble_sort_ctrl;
  logic       clk = 1'b0, rst_n = 1'b0, start = 1'b0, start_s = 1'b0;
  logic [7:0] rd, wd, rd_s, wd_s;
  logic [4:0] addr, addr_s;
  logic       mw, mr, busy, done, mw_s, mr_s, busy_s, done_s;
  logic [15:0] sc, sc_s;
  logic [7:0] mem [32];
  logic [7:0] mem_s [32];
  logic [7:0] orig_s [32];
  logic       ld = 1'b0, ld_s = 1'b0;
  logic [4:0] ld_a = '0;
  logic [7:0] ld_d = '0;
  int         wr_cnt = 0, checks = 0, failures = 0;
  always #5 clk = ~clk;
  bubble_sort_ctrl u_dut (.Clk(clk), .Rst_n(rst_n), .Start(start), .ReadData(rd), .Address(addr),
    .WriteData(wd), .MemWrite(mw), .MemRead(mr), .Busy(busy), .Done(done), .SwapCount(sc));
  bubble_sort_ctrl #(.N(4), .BASE(3)) u_small (.Clk(clk), .Rst_n(rst_n), .Start(start_s),
    .ReadData(rd_s), .Address(addr_s), .WriteData(wd_s), .MemWrite(mw_s), .MemRead(mr_s),
    .Busy(busy_s), .Done(done_s), .SwapCount(sc_s));
  assign rd   = mem[addr];
  assign rd_s = mem_s[addr_s];
  always @(posedge clk) begin
    if (ld) mem[ld_a] <= ld_d;
    else if (mw) begin
      mem[addr] <= wd;
      wr_cnt <= wr_cnt + 1;
    end
    if (ld_s) mem_s[ld_a] <= ld_d;
    else if (mw_s) mem_s[addr_s] <= wd_s;
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic set_mem(input bit s, input int k, input logic [7:0] v);
    @(negedge clk);
    ld = !s; ld_s = s; ld_a = 5'(k); ld_d = v;
    @(negedge clk);
    ld = 0; ld_s = 0;
  endtask
  // swaps = inversions; passes = 1 + max count of larger elements left of any element
  function automatic void model(input logic [7:0] a[$], output int inv, output int cyc);
    int n = a.size(), k = 0, cmp = 0, passes;
    inv = 0;
    for (int j = 0; j < n; j++) begin
      int c = 0;
      for (int x = 0; x < j; x++) if (a[x] > a[j]) c++;
      inv += c;
      if (c > k) k = c;
    end
`ifdef BSORT_EARLY_EXIT_EN
    passes = (k + 1 < n - 1) ? k + 1 : n - 1;
`else
    passes = n - 1;
`endif
    for (int p = 0; p < passes; p++) cmp += n - 1 - p;
    cyc = 3 * cmp + 2 * inv;
  endfunction
  task automatic run(input bit s, output int cyc);
    int n = 0;
    @(negedge clk);
    if (s) start_s = 1; else start = 1;
    @(negedge clk);
    start = 0; start_s = 0; cyc = 0;
    while (!(s ? done_s : done) && n < 6000) begin
      if (s ? busy_s : busy) cyc++;
      n++;
      @(negedge clk);
    end
    chk("done_timeout", 32'(n < 6000), 1);
  endtask
  task automatic do_sort(input string tag, input bit s);
    int base = s ? 3 : 0, n = s ? 4 : 32, inv, cyc, exp_cyc, bad = 0, idx = 0;
    int cnt[256];
    logic [7:0] q[$];
    for (int v = 0; v < 256; v++) cnt[v] = 0;
    for (int k = 0; k < n; k++) q.push_back(s ? mem_s[base + k] : mem[base + k]);
    foreach (q[k]) cnt[q[k]]++;
    model(q, inv, exp_cyc);
    run(s, cyc);
    chk({tag, "_swaps"}, 32'(s ? sc_s : sc), inv);
    chk({tag, "_busy_cycles"}, cyc, exp_cyc);
    chk({tag, "_done"}, {31'd0, s ? done_s : done}, 1);
    for (int v = 0; v < 256; v++)
      for (int r = 0; r < cnt[v]; r++) begin
        if ((s ? mem_s[base + idx] : mem[base + idx]) !== 8'(v)) bad++;
        idx++;
      end
    chk({tag, "_mem_sorted_bad_words"}, bad, 0);
  endtask
  initial begin
    int w0, n, bad;
    #1;
    chk("reset_outputs", {7'd0, addr, wd, mw, mr, busy, done, sc}, 0);
    @(negedge clk) rst_n = 1;
    for (int k = 0; k < 32; k++) set_mem(0, k, 8'(k));
    w0 = wr_cnt;
    do_sort("ascending", 0);
    chk("ascending_writes", wr_cnt - w0, 0);
    for (int k = 0; k < 32; k++) set_mem(0, k, 8'(31 - k));
    do_sort("descending", 0);
    chk("descending_swaps_const", 32'(sc), 496);
    for (int t = 0; t < 3; t++) begin
      for (int k = 0; k < 32; k++) set_mem(0, k, 8'($urandom_range(0, t == 0 ? 3 : 255)));
      do_sort($sformatf("random%0d", t), 0);
    end
    for (int k = 0; k < 32; k++) begin
      orig_s[k] = 8'($urandom);
      set_mem(1, k, k == 3 ? 8'd8 : k == 4 ? 8'd5 : k == 5 ? 8'd2 : k == 6 ? 8'd1 : orig_s[k]);
    end
    do_sort("small", 1);
    chk("small_swaps_const", 32'(sc_s), 6);
    bad = 0;
    for (int k = 0; k < 32; k++) if ((k < 3 || k > 6) && mem_s[k] !== orig_s[k]) bad++;
    chk("small_outside_untouched", bad, 0);
    for (int k = 0; k < 32; k++) set_mem(0, k, 8'(31 - k));
    @(negedge clk) start = 1;
    @(negedge clk) start = 0;
    n = 0;
    while (!(mw && addr == 5'd1) && n < 100) begin
      n++;
      @(negedge clk);
    end
    chk("wr_b_reached", 32'(n < 100), 1);
    #1 rst_n = 0;
    #1;
    chk("async_reset_outputs", {7'd0, addr, wd, mw, mr, busy, done, sc}, 0);
    @(negedge clk);
    chk("duplicated_word", {mem[0], mem[1]}, {8'd30, 8'd30});
    rst_n = 1;
    do_sort("after_abort", 0);
    start_s = 1;
    n = 0;
    while (!done_s && n < 200) begin
      n++;
      @(negedge clk);
    end
    chk("held_start_done", {31'd0, done_s}, 1);
    @(negedge clk);
    chk("held_start_restart", {30'd0, done_s, busy_s}, 1);
    start_s = 0;
    n = 0;
    while (!done_s && n < 200) begin
      n++;
      @(negedge clk);
    end
    chk("held_start_second_done", {31'd0, done_s}, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
